mem_arbiter: RTL

Two-requester arbiter that shares one single-ported, synchronous-read 32-bit memory between the instruction-fetch path and the load/store (MEM-stage) path. Sits between the pipeline's fetch/MEM stages and a unified instruction/data memory. Provides a req/ack handshake per requester, data-first priority with a bounded-starvation guarantee for fetch, and per-requester stall requests for the pipeline controller.

---
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter.sv | 109 ++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, load/store and memory-side signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding pipeline and memory.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_sel;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_ce;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        if_stallreq;
  logic        d_stallreq;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_sel, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack,
    output mem_ce, mem_we, mem_sel, mem_addr, mem_wdata,
    output if_stallreq, d_stallreq
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_sel, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack,
    input  mem_ce, mem_we, mem_sel, mem_addr, mem_wdata,
    input  if_stallreq, d_stallreq
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read memory between fetch and load/store. Data wins by
// default, but a waiting fetch is forced through after MAX_DATA_RUN data grants.
module mem_arbiter #(
  parameter int unsigned MAX_DATA_RUN = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam logic [3:0] RUN_LIMIT = 4'(MAX_DATA_RUN);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_I,
    ISSUE_D,
    RESP_I,
    RESP_D
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  run_q, run_d;
  logic        mem_ce_q, mem_ce_d;
  logic        mem_we_q, mem_we_d;
  logic        store_q, store_d;
  logic [3:0]  mem_sel_q, mem_sel_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        data_wins;

  assign data_wins = bus.d_req && !(bus.if_req && (run_q == RUN_LIMIT));

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    mem_ce_d    = 1'b0;
    mem_we_d    = 1'b0;
    store_d     = store_q;
    mem_sel_d   = mem_sel_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (data_wins) begin
          state_d     = ISSUE_D;
          mem_ce_d    = 1'b1;
          mem_we_d    = bus.d_we;
          store_d     = bus.d_we;
          mem_sel_d   = bus.d_we ? bus.d_sel : 4'hF;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_we ? bus.d_wdata : 32'h0;
          // Only data grants that overtake a waiting fetch count toward the run.
          if (bus.if_req) begin
            run_d = (run_q < RUN_LIMIT) ? run_q + 4'd1 : run_q;
          end else begin
            run_d = 4'd0;
          end
        end else if (bus.if_req) begin
          state_d     = ISSUE_I;
          mem_ce_d    = 1'b1;
          store_d     = 1'b0;
          mem_sel_d   = 4'hF;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = 32'h0;
          run_d       = 4'd0;
        end
      end
      ISSUE_I: state_d = RESP_I;
      ISSUE_D: state_d = RESP_D;
      // Requester's req is still high during its ack cycle, so never arbitrate here.
      RESP_I:  state_d = IDLE;
      RESP_D:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      run_q       <= 4'd0;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      store_q     <= 1'b0;
      mem_sel_q   <= 4'h0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      mem_ce_q    <= mem_ce_d;
      mem_we_q    <= mem_we_d;
      store_q     <= store_d;
      mem_sel_q   <= mem_sel_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.mem_ce      = mem_ce_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_sel     = mem_sel_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.if_ack      = (state_q == RESP_I);
  assign bus.d_ack       = (state_q == RESP_D);
  assign bus.if_rdata    = bus.if_ack ? bus.mem_rdata : 32'h0;
  assign bus.d_rdata     = (bus.d_ack && !store_q) ? bus.mem_rdata : 32'h0;
  assign bus.if_stallreq = bus.if_req & ~bus.if_ack;
  assign bus.d_stallreq  = bus.d_req & ~bus.d_ack;
endmodule
